divider_32bit: RTL and testbench



---
 rtl/divider_32bit_pkg.sv | 14 +
 rtl/divider_32bit_add_sub_33bit.sv | 14 +
 rtl/divider_32bit.sv | 122 ++++++++++++
 tb/tb_divider_32bit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/divider_32bit_pkg.sv
// Shared definitions for the iterative signed divider: state encoding,
// default width and the quotient returned for a zero divisor.
package divider_32bit_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage : divider_32bit_pkg

// File: rtl/divider_32bit_add_sub_33bit.sv
// Combinational two's-complement adder/subtractor: sum = a + b, or a - b when sub=1.
module add_sub_33bit #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    // Subtraction as a + ~b + 1, the carry-in being the sub select itself.
    assign sum = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule : add_sub_33bit

// File: rtl/divider_32bit.sv
// Multi-cycle signed divider: 32-step non-restoring loop on magnitudes,
// then a fix-up cycle that restores the remainder and applies signs.
module divider_32bit
    import divider_32bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q, m;
    logic [CW-1:0]    count;
    logic             sign_q, sign_r, zero_div;

    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_sub;
    logic [WIDTH-1:0] rem_mag, q_signed, r_signed;

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The single adder serves the CALC step and, in FIX, the remainder restore (P + M).
    always_comb begin
        add_a   = {p[WIDTH-1:0], q[WIDTH-1]};
        add_sub = ~p[WIDTH];
        if (state == FIX) begin
            add_a   = p;
            add_sub = 1'b0;
        end
    end

    assign add_b = {1'b0, m};

    add_sub_33bit #(.W(WIDTH + 1)) u_add_sub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (add_sum)
    );

    assign rem_mag  = p[WIDTH] ? add_sum[WIDTH-1:0] : p[WIDTH-1:0];
    assign q_signed = cond_negate(q, sign_q);
    assign r_signed = cond_negate(rem_mag, sign_r);
    assign busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: all datapath registers are reset, not just control, so an aborted
        // operation leaves nothing behind.
        if (!rst_n) begin
            state     <= IDLE;
            p         <= '0;
            q         <= '0;
            m         <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_div  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            div0      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q        <= cond_negate(dividend, dividend[WIDTH-1]);
                        m        <= cond_negate(divisor, divisor[WIDTH-1]);
                        p        <= '0;
                        count    <= '0;
                        sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r   <= dividend[WIDTH-1];
                        zero_div <= (divisor == '0);
                    end
                end
                CALC: begin
                    p     <= add_sum;
                    q     <= {q[WIDTH-2:0], ~add_sum[WIDTH]};
                    count <= count + 1'b1;
                end
                FIX: begin
                    // With M=0 every step subtracts zero, so P ends as |A| and the
                    // signed remainder already equals the dividend.
                    quotient  <= zero_div ? DIV0_QUOTIENT : q_signed;
                    remainder <= r_signed;
                    div0      <= zero_div;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : divider_32bit

// File: tb/tb_divider_32bit.sv
// Directed self-checking bench for divider_32bit: results, latency, busy/done
// timing, divide-by-zero, ignored start, back-to-back start and mid-run reset.
module tb_divider_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend, divisor;
    logic [31:0] quotient, remainder;
    logic        busy, done, div0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int done_seen;

    divider_32bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises start in the current cycle; returns positioned in cycle 1 after the start edge.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Waits for done with a cycle budget; lat is cycles since the start edge.
    task automatic wait_done(input int first_cycle, output int latency);
        int n = first_cycle;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        latency = n - 1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_d0);
        int l;
        do_start(a, b);
        wait_done(1, l);
        check({tag, " latency"}, 32'(l), 32'd33);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " div0"}, {31'b0, div0}, {31'b0, exp_d0});
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset div0", {31'b0, div0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 100 / 7 with a cycle-by-cycle walk of busy and done
        do_start(32'd100, 32'd7);
        for (int k = 1; k <= 33; k++) begin
            check($sformatf("busy cycle %0d", k), {31'b0, busy}, 32'd1);
            check($sformatf("done low cycle %0d", k), {31'b0, done}, 32'd0);
            tick();
        end
        check("done at cycle 34", {31'b0, done}, 32'd1);
        check("busy low with done", {31'b0, busy}, 32'd0);
        check("100/7 quotient", quotient, 32'd14);
        check("100/7 remainder", remainder, 32'd2);
        check("100/7 div0", {31'b0, div0}, 32'd0);
        tick();
        check("done is one pulse", {31'b0, done}, 32'd0);
        check("quotient holds", quotient, 32'd14);

        run_op("-100/7", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_op("100/-7", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
        run_op("7/-100", 32'd7, -32'sd100, 32'd0, 32'd7, 1'b0);
        run_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_op("max/1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0);
        run_op("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_op("-9/0", -32'sd9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1);
        run_op("9/3 after div0", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        tick();

        // Start pulse at cycle 10 of a running operation is ignored
        do_start(32'd100, 32'd7);
        repeat (9) tick();
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        tick();
        start = 1'b0;
        wait_done(11, lat);
        check("ignored start latency", 32'(lat), 32'd33);
        check("ignored start quotient", quotient, 32'd14);
        check("ignored start remainder", remainder, 32'd2);

        // Start raised in the done cycle is accepted immediately
        run_op("back-to-back 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Reset at cycle 15 aborts the operation and clears the outputs
        do_start(32'd100, 32'd7);
        repeat (14) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort div0", {31'b0, div0}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        check("abort no done", 32'(done_seen), 32'd0);
        check("abort stays idle", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_divider_32bit
